neuron_mac: RTL and testbench
=============================

# neuron_mac

Weight-streaming multiply-accumulate stage for one neuron of the recognition network. It issues one burst read to the 32-bit BRAM read controller that sits directly upstream. It consumes the returned weight words, each holding four signed 8-bit weights. Each word is combined with a matching 32-bit word of four unsigned 8-bit pixels, and the dot product is accumulated into a signed result for the activation stage.

## Interface
- ACC_W, 32: accumulator and result width in bits; legal range 20..32.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to compute one neuron; sampled only in IDLE.
- base_address  input  8  BRAM word address of the first weight word.
- word_count  input  8  number of weight words to consume (0..255).
- mem_trigger  output  1  one-cycle read request to the BRAM controller.
- mem_read_or_write  output  1  constant 1 (read).
- mem_start_address  output  8  registered copy of base_address.
- mem_no_of_words  output  8  registered copy of word_count.
- mem_data  input  32  weight word; bits [8k+7:8k] hold weight lane k.
- mem_valid  input  1  qualifies mem_data.
- pix_index  output  8  index of the weight word currently expected (0-based).
- pix_data  input  32  pixel word for pix_index, sampled in the same cycle as mem_valid.
- busy  output  1  high from the cycle after start is accepted until result_valid.
- result  output  ACC_W  signed dot product; holds until the next accepted start.
- result_valid  output  1  one-cycle pulse when result is final.
- sat_flag  output  1  sticky per job; set if any accumulation saturated.

## Operation
- States: IDLE, REQ, ACC, FLUSH, DONE.
- IDLE
  - On start=1: capture base_address and word_count, clear the accumulator, pipeline, idx and sat_flag.
  - If word_count==0, go to FLUSH; otherwise go to REQ.
- REQ: mem_trigger=1 for exactly one cycle, then go to ACC.
- ACC
  - Each cycle with mem_valid=1: lane products p_k = signed(w_k) * unsigned(x_k), 17-bit signed.
  - The 4-lane sum (19-bit signed) is registered into the partial stage with a valid bit, and idx increments.
  - When the word with idx==word_count-1 is consumed, go to FLUSH.
  - mem_valid outside ACC is ignored.
- Stage 2: when the partial-stage valid bit is set, acc <= acc + sign-extended partial.
- FLUSH: waits one cycle for stage 2 to drain, then go to DONE.
- DONE: result_valid=1, result=acc; go to IDLE.
- start outside IDLE is ignored; there is no queueing.
- pix_index=idx at all times; it is 0 in IDLE.
- Reset values: state IDLE, all outputs 0 (mem_read_or_write=1), accumulator 0.
- Reset mid-job aborts the job. No result_valid is produced. The BRAM controller shares the same reset.

## Timing
- Cycle 0: start=1 in IDLE. Cycle 1: REQ, mem_trigger=1, busy=1.
- mem_start_address and mem_no_of_words are stable from cycle 1 until result_valid.
- Words may arrive with any latency and any gaps; each valid cycle consumes exactly one word.
- With the last word consumed in cycle L: FLUSH in L+1, result_valid in L+2, busy falls in L+3.
- Zero-length job: start in cycle 0, FLUSH in cycle 1, result_valid=1 with result=0 in cycle 2, no mem_trigger.
- Back-to-back: start is accepted again in the cycle after result_valid.

## Configuration
- NEURON_MAC_SAT_EN defined: stage-2 addition saturates to the signed ACC_W bounds [-2^(ACC_W-1), 2^(ACC_W-1)-1], and sat_flag is set and held until the next accepted start.
- Not defined: two's-complement wrap at ACC_W bits, and sat_flag is tied to 0.

## Structure
- Package neuron_mac_pkg holds:
  - the state encoding (IDLE..DONE);
  - LANES=4, LANE_W=8, PROD_W=17, SUM4_W=19.
- Sub-module dot4: combinational 4-lane signed×unsigned dot product (32-bit weights, 32-bit pixels → 19-bit signed). It is instantiated once, in front of the partial-stage register.

## Test plan
- word_count=1, mem_data=0x04030201, pix_data=0x0A0A0A0A → one mem_trigger; result=100 two cycles after the word; sat_flag=0.
- word_count=3, mem_data=0xFFFFFFFF each word, pix_data=0xFFFFFFFF, with one idle cycle inserted between words → result=-3060 (signed); pix_index steps 0,1,2.
- word_count=0 → no mem_trigger; result_valid in cycle 2 with result=0.
- ACC_W=20, NEURON_MAC_SAT_EN defined, 5 words of 0x7F7F7F7F with pix_data 0xFFFFFFFF → result=524287, sat_flag=1.
  - Same stimulus without the macro → result=647700 mod 2^20, read as signed = -400876; sat_flag=0.
- Reset asserted after the 2nd of 4 words, then a new start with word_count=1, mem_data=0x00000002, pix_data=0x00000003 → no result_valid from the aborted job; result=6.
- start pulsed again during ACC → ignored, mem_trigger count stays 1, and the result equals the single-job value.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared types and widths for the neuron_mac weight-streaming MAC stage.
package neuron_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACC,
    FLUSH,
    DONE
  } state_t;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned SUM4_W = 19;

endpackage

// File: rtl/neuron_mac_dot4.sv
// Combinational 4-lane dot product: signed 8-bit weights times unsigned 8-bit pixels.
module dot4
  import neuron_mac_pkg::*;
(
  input  logic [LANES*LANE_W-1:0]  w,
  input  logic [LANES*LANE_W-1:0]  x,
  output logic signed [SUM4_W-1:0] sum
);

  logic signed [PROD_W-1:0] p;

  // Pixels get a zero MSB so the signed multiply treats them as unsigned.
  always_comb begin
    p   = '0;
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      p   = PROD_W'($signed(w[k*LANE_W +: LANE_W])) *
            PROD_W'($signed({1'b0, x[k*LANE_W +: LANE_W]}));
      sum = sum + SUM4_W'(p);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// One-neuron weight-streaming MAC: burst-reads weights, dots them with pixels, accumulates.
// Optional saturating accumulation is enabled with `define NEURON_MAC_SAT_EN.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              base_address,
  input  logic [7:0]              word_count,
  output logic                    mem_trigger,
  output logic                    mem_read_or_write,
  output logic [7:0]              mem_start_address,
  output logic [7:0]              mem_no_of_words,
  input  logic [31:0]             mem_data,
  input  logic                    mem_valid,
  output logic [7:0]              pix_index,
  input  logic [31:0]             pix_data,
  output logic                    busy,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic                    sat_flag
);

  state_t                    state;
  logic [7:0]                idx;
  logic signed [SUM4_W-1:0]  sum4;
  logic signed [SUM4_W-1:0]  part;
  logic                      part_valid;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;

  assign mem_read_or_write = 1'b1;
  assign pix_index         = idx;

  dot4 u_dot4 (
    .w   (mem_data),
    .x   (pix_data),
    .sum (sum4)
  );

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] wide;
  logic                  sat_hit;

  // One guard bit exposes signed overflow of the stage-2 add.
  always_comb begin
    wide     = (ACC_W+1)'(acc) + (ACC_W+1)'(part);
    acc_next = acc;
    sat_hit  = 1'b0;
    if (part_valid) begin
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        acc_next = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_hit  = 1'b1;
      end else begin
        acc_next = wide[ACC_W-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_next = acc;
    if (part_valid) acc_next = acc + ACC_W'(part);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      part              <= '0;
      part_valid        <= 1'b0;
      acc               <= '0;
      result            <= '0;
      result_valid      <= 1'b0;
      sat_flag          <= 1'b0;
      mem_trigger       <= 1'b0;
      busy              <= 1'b0;
      mem_start_address <= '0;
      mem_no_of_words   <= '0;
    end else begin
      acc          <= acc_next;
      part_valid   <= 1'b0;
      mem_trigger  <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_start_address <= base_address;
            mem_no_of_words   <= word_count;
            acc               <= '0;
            idx               <= '0;
            sat_flag          <= 1'b0;
            busy              <= 1'b1;
            if (word_count == 8'd0) begin
              state <= FLUSH;
            end else begin
              state       <= REQ;
              mem_trigger <= 1'b1;
            end
          end
        end
        REQ: state <= ACC;
        ACC: begin
          if (mem_valid) begin
            part       <= sum4;
            part_valid <= 1'b1;
            idx        <= idx + 8'd1;
            if (idx == 8'(mem_no_of_words - 8'd1)) state <= FLUSH;
          end
        end
        // Stage 2 drains this cycle, so publish the post-add value directly.
        FLUSH: begin
          result       <= acc_next;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef NEURON_MAC_SAT_EN
      if (sat_hit) sat_flag <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (ACC_W=20); expectations follow NEURON_MAC_SAT_EN.
module tb_neuron_mac;

  localparam int unsigned ACC_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        base_address;
  logic [7:0]        word_count;
  logic              mem_trigger;
  logic              mem_read_or_write;
  logic [7:0]        mem_start_address;
  logic [7:0]        mem_no_of_words;
  logic [31:0]       mem_data;
  logic              mem_valid;
  logic [7:0]        pix_index;
  logic [31:0]       pix_data;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              sat_flag;

  neuron_mac #(.ACC_W(ACC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .word_count        (word_count),
    .mem_trigger       (mem_trigger),
    .mem_read_or_write (mem_read_or_write),
    .mem_start_address (mem_start_address),
    .mem_no_of_words   (mem_no_of_words),
    .mem_data          (mem_data),
    .mem_valid         (mem_valid),
    .pix_index         (pix_index),
    .pix_data          (pix_data),
    .busy              (busy),
    .result            (result),
    .result_valid      (result_valid),
    .sat_flag          (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             sat;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          trig_cnt = 0;
  logic [31:0] wv [8];
  logic [31:0] xv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: count read requests and score every presented result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mem_trigger) trig_cnt++;
    if (result_valid) begin
      if (q.size() == 0) begin
        check("unexpected_result_valid", 32'(result_valid), 32'(0));
      end else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("sat_flag", 32'(sat_flag), 32'(e.sat));
      end
    end
  end

  // Caller sits on a negedge in IDLE; returns on the negedge where busy has fallen.
  task automatic run_job(input int n, input int gap, input int poke_idx,
                         input int abort_after, input int exp_res, input logic exp_sat);
    exp_t e;
    int   t0;
    t0 = trig_cnt;
    if (abort_after < 0) begin
      e.res = ACC_W'(exp_res);
      e.sat = exp_sat;
      q.push_back(e);
    end
    start        = 1'b1;
    base_address = 8'(8'h40 + n);
    word_count   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    check("mem_trigger_cycle1", 32'(mem_trigger), (n > 0) ? 32'(1) : 32'(0));
    if (n > 0) begin
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          for (int g = 0; g < gap; g++) begin
            mem_valid = 1'b0;
            mem_data  = 32'h8080_8080;
            pix_data  = 32'hFFFF_FFFF;
            @(negedge clk);
          end
        end
        check("pix_index", 32'(pix_index), 32'(i));
        check("mem_start_address", 32'(mem_start_address), 32'(8'h40 + n));
        mem_valid = 1'b1;
        mem_data  = wv[i];
        pix_data  = xv[i];
        start     = (i == poke_idx);
        @(negedge clk);
        mem_valid = 1'b0;
        start     = 1'b0;
        if (i + 1 == abort_after) begin
          reset = 1'b1;
          @(negedge clk);
          check("abort_busy", 32'(busy), 32'(0));
          check("abort_result", 32'(result), 32'(0));
          check("abort_pix_index", 32'(pix_index), 32'(0));
          reset = 1'b0;
          @(negedge clk);
          return;
        end
      end
    end
    check("result_valid_flush", 32'(result_valid), 32'(0));
    @(negedge clk);
    check("result_valid_timing", 32'(result_valid), 32'(1));
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'(0));
    check("pix_index_idle", 32'(pix_index), 32'(0));
    check("trigger_count", 32'(trig_cnt - t0), (n > 0) ? 32'(1) : 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_res;
    logic sat_exp;
    reset = 1'b1; start = 1'b0; base_address = '0; word_count = '0;
    mem_data = '0; mem_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_mem_trigger", 32'(mem_trigger), 32'(0));
    check("rst_read_or_write", 32'(mem_read_or_write), 32'(1));
    check("rst_result_valid", 32'(result_valid), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    wv[0] = 32'h0403_0201; xv[0] = 32'h0A0A_0A0A;
    run_job(1, 0, -1, -1, 100, 1'b0);

    for (int i = 0; i < 3; i++) begin wv[i] = 32'hFFFF_FFFF; xv[i] = 32'hFFFF_FFFF; end
    run_job(3, 1, -1, -1, -3060, 1'b0);

    run_job(0, 0, -1, -1, 0, 1'b0);

    wv[0] = 32'h80FF_0102; xv[0] = 32'h0102_0304;
    run_job(1, 0, -1, -1, -119, 1'b0);

`ifdef NEURON_MAC_SAT_EN
    sat_res = 524287;  sat_exp = 1'b1;
`else
    sat_res = -400876; sat_exp = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin wv[i] = 32'h7F7F_7F7F; xv[i] = 32'hFFFF_FFFF; end
    run_job(5, 0, -1, -1, sat_res, sat_exp);

    for (int i = 0; i < 4; i++) begin wv[i] = 32'h0101_0101; xv[i] = 32'h0505_0505; end
    run_job(4, 0, -1, 2, 0, 1'b0);

    wv[0] = 32'h0000_0002; xv[0] = 32'h0000_0003;
    run_job(1, 0, -1, -1, 6, 1'b0);

    for (int i = 0; i < 2; i++) begin wv[i] = 32'h0101_0101; xv[i] = 32'h0202_0202; end
    run_job(2, 2, 1, -1, 16, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
